// File: rtl/fp_mult_seq.sv
// fp_mult_seq: multi-cycle floating-point multiplier.
// One shared shift-and-add mantissa datapath handles one multiplier bit per
// cycle under FSM control. Special-case detection, exponent arithmetic,
// normalisation and status flags are built around it. Operands arrive over
// a valid/ready handshake and results leave over a second one.
// Optional feature macro: FP_MULT_SEQ_ROUND_EN selects round-to-nearest-even
// in NORM. When it is undefined, NORM truncates the mantissa.
module fp_mult_seq #(
  parameter int E    = 8,
  parameter int M    = 23,
  parameter int BITS = 1 + E + M,
  parameter int EB   = 2**(E-1) - 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] X,
  input  logic [BITS-1:0] Y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] result,
  output logic            zero,
  output logic            underflow,
  output logic            overflow,
  output logic            nan
);

  localparam int W  = 2*M + 2;       // full product width
  localparam int CW = $clog2(M + 2); // counter must hold M+1
  localparam int XW = E + 2;         // signed working exponent width

  localparam logic signed [XW-1:0] EXP_BIAS = XW'(EB);
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_ZERO = XW'(0);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'(2**E - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MULT,
    S_NORM,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [BITS-1:0]       r_x;
  logic [BITS-1:0]       r_y;
  logic                  r_sign;
  logic signed [XW-1:0]  r_exp;
  logic [W-1:0]          r_acc;
  logic [W-1:0]          r_mcand;
  logic [M:0]            r_mplier;
  logic [CW-1:0]         r_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [BITS-1:0]       r_result;
  logic                  r_zero;
  logic                  r_underflow;
  logic                  r_overflow;
  logic                  r_nan;

  // Operand field decode from the captured operands
  logic                  w_sign;
  logic [E-1:0]          w_xe;
  logic [E-1:0]          w_ye;
  logic [M-1:0]          w_xm;
  logic [M-1:0]          w_ym;
  logic                  w_any_inf;
  logic                  w_any_zero;
  logic signed [XW-1:0]  w_exp_sum;

  assign w_sign     = r_x[BITS-1] ^ r_y[BITS-1];
  assign w_xe       = r_x[BITS-2:M];
  assign w_ye       = r_y[BITS-2:M];
  assign w_xm       = r_x[M-1:0];
  assign w_ym       = r_y[M-1:0];
  assign w_any_inf  = (&w_xe) | (&w_ye);
  assign w_any_zero = ~(|w_xe) | ~(|w_ye);
  assign w_exp_sum  = $signed({2'b00, w_xe}) + $signed({2'b00, w_ye}) - EXP_BIAS;

  // One shift-and-add step: add the multiplicand when the multiplier LSB is set
  logic [W-1:0] w_acc_add;
  assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Normalisation: the product of two [1,2) mantissas lies in [1,4)
  logic                  w_top;
  logic [M-1:0]          w_mant_t;
  logic signed [XW-1:0]  w_exp_t;
  logic [M-1:0]          w_mant_n;
  logic signed [XW-1:0]  w_exp_n;

  assign w_top    = r_acc[2*M+1];
  assign w_mant_t = w_top ? r_acc[2*M:M+1] : r_acc[2*M-1:M];
  assign w_exp_t  = w_top ? (r_exp + EXP_ONE) : r_exp;

`ifdef FP_MULT_SEQ_ROUND_EN
  // Round to nearest, ties to even. The guard is the first dropped bit and
  // sticky is the OR of everything below the guard.
  logic         w_guard;
  logic         w_sticky;
  logic         w_round_up;
  logic [M:0]   w_mant_inc;

  assign w_guard    = w_top ? r_acc[M] : r_acc[M-1];
  assign w_sticky   = w_top ? (|r_acc[M-1:0]) : (|r_acc[M-2:0]);
  assign w_round_up = w_guard & (w_sticky | w_mant_t[0]);
  assign w_mant_inc = {1'b0, w_mant_t} + {{M{1'b0}}, w_round_up};
  // On carry-out the low bits are already zero (all-ones plus one)
  assign w_mant_n   = w_mant_inc[M-1:0];
  assign w_exp_n    = w_mant_inc[M] ? (w_exp_t + EXP_ONE) : w_exp_t;
`else
  // Truncation drops the low product bits entirely
  logic w_unused_tail;
  assign w_unused_tail = ^r_acc[M-1:0];
  assign w_mant_n      = w_mant_t;
  assign w_exp_n       = w_exp_t;
`endif

  // Controller FSM with datapath registers and registered handshake/outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
      r_nan       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x        <= X;
            r_y        <= Y;
            r_in_ready <= 1'b0;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_sign <= w_sign;
          if (w_any_inf) begin
            r_result    <= {w_sign, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            r_nan       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_any_zero) begin
            // Denormal operands are flushed to zero
            r_result    <= {w_sign, {(BITS-1){1'b0}}};
            r_zero      <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_mcand  <= {{(M+1){1'b0}}, 1'b1, w_xm};
            r_mplier <= {1'b1, w_ym};
            r_acc    <= '0;
            r_cnt    <= CW'(M + 1);
            r_exp    <= w_exp_sum;
            r_state  <= S_MULT;
          end
        end
        S_MULT: begin
          r_acc    <= w_acc_add;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (w_exp_n >= EXP_MAX) begin
            r_result   <= {r_sign, {E{1'b1}}, {M{1'b0}}};
            r_overflow <= 1'b1;
          end else if (w_exp_n <= EXP_ZERO) begin
            r_result    <= {r_sign, {(BITS-1){1'b0}}};
            r_underflow <= 1'b1;
            r_zero      <= 1'b1;
          end else begin
            r_result <= {r_sign, w_exp_n[E-1:0], w_mant_n};
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          // Result and flags hold until the consumer takes them
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_nan       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign underflow = r_underflow;
  assign overflow  = r_overflow;
  assign nan       = r_nan;

endmodule
